// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end with a DEPTH-entry prefetch queue,
//               redirect/flush, sticky fetch-fault reporting and optional
//               vectored interrupt entry.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   ram_txs/ram_re     : RAM transaction start/hold and read enable
//   ram_addr           : RAM fetch address
//   ram_txe/ram_err    : RAM transaction end / error (error qualified by txe)
//   ram_out            : RAM read data (qualified by txe)
//   instr_valid/instr  : queue head valid / instruction
//   instr_addr         : address of the queue head instruction
//   instr_take         : pop the queue head
//   redir/redir_addr   : flush and restart fetching at redir_addr
//   fault/fault_addr   : sticky fetch fault and the failing address
//   int_req            : interrupt request, level-sensitive ("int" is a
//                        SystemVerilog keyword, so the port carries a suffix)
//   int_dev_id/int_en  : interrupting device / global interrupt enable
//   int_taken          : one-cycle pulse on interrupt entry
//   int_ret_addr       : return address, valid while int_taken is 1
//
// Configuration macro : FETCH_UNIT_INT_EN enables interrupt entry; when it is
//                       undefined the interrupt inputs are ignored and
//                       int_taken/int_ret_addr are tied to zero.
//
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       INSTR_W    = 32,
    parameter int unsigned       DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'('h100),
    parameter int unsigned       VEC_STRIDE = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               ram_txs,
    output logic               ram_re,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic               ram_txe,
    input  logic               ram_err,
    input  logic [INSTR_W-1:0] ram_out,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic               instr_take,
    input  logic               redir,
    input  logic [ADDR_W-1:0]  redir_addr,
    output logic               fault,
    output logic [ADDR_W-1:0]  fault_addr,
    input  logic               int_req,
    input  logic [7:0]         int_dev_id,
    input  logic               int_en,
    output logic               int_taken,
    output logic [ADDR_W-1:0]  int_ret_addr
);

    localparam int unsigned         c_PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned         c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]   c_PC_STEP   = ADDR_W'(INSTR_W / 8);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_BUSY  = 2'd1;
    localparam logic [1:0] c_ST_DROP  = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_ram_txs;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_fault;
    logic [ADDR_W-1:0]   r_fault_addr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic [INSTR_W-1:0]  r_q_data [DEPTH];
    logic [ADDR_W-1:0]   r_q_addr [DEPTH];

    logic                w_issue;
    logic                w_push;
    logic                w_pop;
    logic                w_fault_set;
    logic                w_int_entry;
    logic                w_flush;
    logic [ADDR_W-1:0]   w_flush_addr;
    logic [ADDR_W-1:0]   w_vec_addr;

    assign w_vec_addr   = VEC_BASE + ADDR_W'(int_dev_id) * ADDR_W'(VEC_STRIDE);
    assign w_flush      = redir | w_int_entry;
    assign w_flush_addr = redir ? redir_addr : w_vec_addr;
    assign w_pop        = instr_take && (r_count != '0) && !w_flush;

    // ------------------------------------------------------------------------
    // Fetch FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Fetch FSM: next state and per-cycle actions
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_fault_set = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_flush && (r_count < c_DEPTH_CNT) && !ram_txe) begin
                    w_issue     = 1'b1;
                    w_state_nxt = c_ST_BUSY;
                end
            end
            c_ST_BUSY: begin
                if (ram_txe) begin
                    if (ram_err) begin
                        w_fault_set = 1'b1;
                        w_state_nxt = c_ST_FAULT;
                    end else begin
                        w_push      = 1'b1;
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_DROP: begin
                if (ram_txe) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_FAULT;
            end
        endcase
        // A flush overrides everything. A transaction ending on this very
        // cycle is simply discarded; one still open is waited out in DROP
        // because the RAM port cannot abort it.
        if (w_flush) begin
            w_push      = 1'b0;
            w_fault_set = 1'b0;
            if (((r_state == c_ST_BUSY) || (r_state == c_ST_DROP)) && !ram_txe) begin
                w_state_nxt = c_ST_DROP;
            end else begin
                w_state_nxt = c_ST_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // PC, RAM request, fault and queue bookkeeping
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_ADDR;
            r_ram_txs    <= 1'b0;
            r_ram_addr   <= '0;
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
        end else begin
            // Request stays up for as long as a transaction is open.
            r_ram_txs <= (w_state_nxt == c_ST_BUSY) || (w_state_nxt == c_ST_DROP);
            if (w_issue) begin
                r_ram_addr <= r_pc;
            end

            // The PC only advances on a successful push, so it always names
            // the address of the transaction currently in flight.
            if (w_flush) begin
                r_pc <= w_flush_addr;
            end else if (w_push) begin
                r_pc <= r_pc + c_PC_STEP;
            end

            if (w_flush) begin
                r_fault <= 1'b0;
            end else if (w_fault_set) begin
                r_fault      <= 1'b1;
                r_fault_addr <= r_pc;
            end

            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
        end
    end

    // Queue storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= ram_out;
            r_q_addr[r_wr_ptr] <= r_pc;
        end
    end

`ifdef FETCH_UNIT_INT_EN
    logic              r_in_isr;
    logic              r_int_taken;
    logic [ADDR_W-1:0] r_int_ret_addr;

    assign w_int_entry = int_req && int_en && !r_in_isr && !redir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_isr       <= 1'b0;
            r_int_taken    <= 1'b0;
            r_int_ret_addr <= '0;
        end else begin
            r_int_taken <= w_int_entry;
            if (redir) begin
                r_in_isr <= 1'b0;
            end else if (w_int_entry) begin
                r_in_isr <= 1'b1;
            end
            // Resume at the oldest unexecuted instruction if one is queued,
            // otherwise at the address being fetched.
            if (w_int_entry) begin
                r_int_ret_addr <= (r_count != '0) ? r_q_addr[r_rd_ptr] : r_pc;
            end
        end
    end

    assign int_taken    = r_int_taken;
    assign int_ret_addr = r_int_ret_addr;
`else
    logic w_unused_int;

    assign w_int_entry  = 1'b0;
    assign int_taken    = 1'b0;
    assign int_ret_addr = '0;
    assign w_unused_int = &{1'b0, int_req, int_en, w_vec_addr};
`endif

    assign ram_txs     = r_ram_txs;
    assign ram_re      = r_ram_txs;
    assign ram_addr    = r_ram_addr;
    assign fault       = r_fault;
    assign fault_addr  = r_fault_addr;
    assign instr_valid = (r_count != '0);
    assign instr       = r_q_data[r_rd_ptr];
    assign instr_addr  = r_q_addr[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. A small memory
//               model answers each request after a programmable number of
//               cycles with data 'h1000 + address, optionally with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ram_txs;
    logic        ram_re;
    logic [63:0] ram_addr;
    logic        ram_txe = 1'b0;
    logic        ram_err = 1'b0;
    logic [31:0] ram_out = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_addr;
    logic        instr_take = 1'b0;
    logic        redir = 1'b0;
    logic [63:0] redir_addr = '0;
    logic        fault;
    logic [63:0] fault_addr;
    logic        int_req = 1'b0;
    logic [7:0]  int_dev_id = '0;
    logic        int_en = 1'b0;
    logic        int_taken;
    logic [63:0] int_ret_addr;

    int          n_checks = 0;
    int          n_errors = 0;
    int          mem_lat  = 0;
    int          wait_cnt = 0;
    logic        err_en   = 1'b0;
    logic [63:0] err_addr = '0;

    fetch_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .ram_txs      (ram_txs),
        .ram_re       (ram_re),
        .ram_addr     (ram_addr),
        .ram_txe      (ram_txe),
        .ram_err      (ram_err),
        .ram_out      (ram_out),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_addr   (instr_addr),
        .instr_take   (instr_take),
        .redir        (redir),
        .redir_addr   (redir_addr),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .int_req      (int_req),
        .int_dev_id   (int_dev_id),
        .int_en       (int_en),
        .int_taken    (int_taken),
        .int_ret_addr (int_ret_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Memory model: responds mem_lat negedges after it first sees a request.
    initial begin
        forever begin
            @(negedge clk);
            if (rst || !ram_txs || ram_txe) begin
                ram_txe  = 1'b0;
                ram_err  = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= mem_lat) begin
                ram_txe = 1'b1;
                ram_out = 32'h1000 + ram_addr[31:0];
                ram_err = err_en && (ram_addr == err_addr);
            end else begin
                wait_cnt++;
            end
        end
    end

    task automatic reset_dut();
        tick();
        instr_take = 1'b0;
        redir      = 1'b0;
        int_req    = 1'b0;
        int_en     = 1'b0;
        err_en     = 1'b0;
        rst        = 1'b1;
        #1;
        check("rst_txs",      {63'b0, ram_txs},     64'd0);
        check("rst_re",       {63'b0, ram_re},      64'd0);
        check("rst_addr",     ram_addr,             64'd0);
        check("rst_valid",    {63'b0, instr_valid}, 64'd0);
        check("rst_fault",    {63'b0, fault},       64'd0);
        check("rst_faddr",    fault_addr,           64'd0);
        check("rst_itaken",   {63'b0, int_taken},   64'd0);
        check("rst_iret",     int_ret_addr,         64'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int          n;
        int          pulses;
        logic [63:0] exp_addr;

        // ---------------- sequential fill ----------------
        mem_lat = 0;
        reset_dut();
        repeat (12) tick();
        check("fill_txs_stop", {63'b0, ram_txs},     64'd0);
        check("fill_valid",    {63'b0, instr_valid}, 64'd1);
        check("fill_head_a",   instr_addr,           64'h0);
        check("fill_head_d",   instr,                64'h1000);
        instr_take = 1'b1;
        tick();
        instr_take = 1'b0;
        check("fill_pop_a",    instr_addr,           64'h4);
        check("fill_pop_d",    instr,                64'h1004);
        check("fill_pop_txs",  {63'b0, ram_txs},     64'd0);
        tick();
        check("fill_iss_txs",  {63'b0, ram_txs},     64'd1);
        check("fill_iss_addr", ram_addr,             64'h10);

        // ---------------- streaming ----------------
        exp_addr   = 64'h4;
        n          = 0;
        instr_take = 1'b1;
        for (int i = 0; i < 100 && n < 16; i++) begin
            if (instr_valid) begin
                check("stream_addr", instr_addr, exp_addr);
                check("stream_data", {32'b0, instr}, 64'h1000 + exp_addr);
                exp_addr += 64'h4;
                n++;
            end
            tick();
        end
        instr_take = 1'b0;
        check("stream_len", 64'(n), 64'd16);

        // ---------------- redirect in flight ----------------
        mem_lat = 3;
        reset_dut();
        for (int i = 0; i < 100 && !(ram_txs && ram_addr == 64'h8); i++) tick();
        check("redir_busy8", {63'b0, (ram_txs && ram_addr == 64'h8)}, 64'd1);
        redir      = 1'b1;
        redir_addr = 64'h200;
        tick();
        redir = 1'b0;
        check("redir_valid",   {63'b0, instr_valid}, 64'd0);
        check("redir_hold",    {63'b0, ram_txs},     64'd1);
        check("redir_hold_a",  ram_addr,             64'h8);
        for (int i = 0; i < 20 && ram_txs; i++) tick();
        check("drop_done",     {63'b0, ram_txs},     64'd0);
        check("drop_no_push",  {63'b0, instr_valid}, 64'd0);
        tick();
        check("redir_iss",     {63'b0, ram_txs},     64'd1);
        check("redir_iss_a",   ram_addr,             64'h200);
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check("redir_first_v", {63'b0, instr_valid}, 64'd1);
        check("redir_first_a", instr_addr,           64'h200);
        check("redir_first_d", {32'b0, instr},       64'h1200);

        // ---------------- fetch fault ----------------
        mem_lat  = 0;
        reset_dut();
        err_en   = 1'b1;
        err_addr = 64'hC;
        for (int i = 0; i < 40 && !fault; i++) tick();
        check("fault_set",   {63'b0, fault},   64'd1);
        check("fault_addr",  fault_addr,       64'hC);
        check("fault_head",  instr_addr,       64'h0);
        repeat (4) tick();
        check("fault_no_iss", {63'b0, ram_txs}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            check("fault_q_v", {63'b0, instr_valid}, 64'd1);
            check("fault_q_a", instr_addr, 64'(4 * k));
            instr_take = 1'b1;
            tick();
            instr_take = 1'b0;
        end
        check("fault_q_empty", {63'b0, instr_valid}, 64'd0);
        check("fault_sticky",  {63'b0, fault},       64'd1);
        redir      = 1'b1;
        redir_addr = 64'h0;
        tick();
        redir  = 1'b0;
        err_en = 1'b0;
        check("fault_clr",     {63'b0, fault},   64'd0);
        check("fault_clr_txs", {63'b0, ram_txs}, 64'd0);
        tick();
        check("fault_rest",    {63'b0, ram_txs}, 64'd1);
        check("fault_rest_a",  ram_addr,         64'h0);

        // ---------------- interrupts ----------------
`ifdef FETCH_UNIT_INT_EN
        mem_lat    = 0;
        reset_dut();
        redir      = 1'b1;
        redir_addr = 64'h40;
        tick();
        redir = 1'b0;
        for (int i = 0; i < 20 && !instr_valid; i++) tick();
        check("int_head", instr_addr, 64'h40);
        int_req    = 1'b1;
        int_dev_id = 8'd3;
        int_en     = 1'b1;
        tick();
        check("int_pulse",   {63'b0, int_taken},   64'd1);
        check("int_ret",     int_ret_addr,         64'h40);
        check("int_flush",   {63'b0, instr_valid}, 64'd0);
        tick();
        check("int_pulse_1", {63'b0, int_taken},   64'd0);
        check("int_vec_txs", {63'b0, ram_txs},     64'd1);
        check("int_vec_a",   ram_addr,             64'h130);
        pulses = 0;
        repeat (8) begin
            tick();
            if (int_taken) pulses++;
        end
        check("int_no_repeat", 64'(pulses), 64'd0);
        redir      = 1'b1;
        redir_addr = 64'h40;
        tick();
        redir = 1'b0;
        check("int_redir_prio", {63'b0, int_taken}, 64'd0);
        tick();
        check("int_reentry",    {63'b0, int_taken}, 64'd1);
        check("int_reentry_r",  int_ret_addr,       64'h40);
        int_req = 1'b0;
        tick();
        check("int_reentry_v",  ram_addr,           64'h130);
`else
        mem_lat    = 0;
        reset_dut();
        int_req    = 1'b1;
        int_dev_id = 8'd3;
        int_en     = 1'b1;
        pulses     = 0;
        repeat (10) begin
            tick();
            if (int_taken) pulses++;
        end
        check("noint_pulses", 64'(pulses),          64'd0);
        check("noint_ret",    int_ret_addr,         64'd0);
        check("noint_valid",  {63'b0, instr_valid}, 64'd1);
        check("noint_head",   instr_addr,           64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
